// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial add/subtract engine.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // Bit-counter width; clamps to one bit so a degenerate width still elaborates.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// One-bit full-adder cell, reused every cycle by the serial controller.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic c,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ c;
    assign co = (x & y) | ((x ^ y) & c);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: shifts operands LSB-first through one full-adder cell.
//  state | meaning
//  IDLE  | waiting for operands, in_ready high
//  RUN   | one result bit per edge, WIDTH edges
//  DONE  | result held until downstream accepts
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MSB_IN = CNT_W'(WIDTH - 2);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             carry_q, carry_d;
    logic             cin_msb_q, cin_msb_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             fa_sum, fa_cout;

    fa_cell u_fa (
        .x  (a_sr_q[0]),
        .y  (b_sr_q[0]),
        .c  (carry_q),
        .s  (fa_sum),
        .co (fa_cout)
    );

    always_comb begin
        state_d   = state_q;
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        sum_sr_d  = sum_sr_q;
        count_d   = count_q;
        carry_d   = carry_q;
        cin_msb_d = cin_msb_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtract as A + ~B + 1, the +1 entering as the initial carry.
                    a_sr_d  = a;
                    b_sr_d  = sub ? ~b : b;
                    carry_d = sub;
                    count_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_sr_d = {fa_sum, sum_sr_q[WIDTH-1:1]};
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                carry_d  = fa_cout;
                count_d  = count_q + CNT_W'(1);
                if (count_q == CNT_MSB_IN) begin
                    cin_msb_d = fa_cout;
                end
                if (count_q == CNT_LAST) begin
                    cout_d  = fa_cout;
                    ovf_d   = cin_msb_q ^ fa_cout;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_sr_q    <= '0;
            b_sr_q    <= '0;
            sum_sr_q  <= '0;
            count_q   <= '0;
            carry_q   <= 1'b0;
            cin_msb_q <= 1'b0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sr_q    <= a_sr_d;
            b_sr_q    <= b_sr_d;
            sum_sr_q  <= sum_sr_d;
            count_q   <= count_d;
            carry_q   <= carry_d;
            cin_msb_q <= cin_msb_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_sr_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial add/subtract engine: one 1-bit full-adder cell is reused over WIDTH cycles to compute a WIDTH-bit result.
- Controller owns operand shift registers, the carry flop, a bit counter and the FSM.
- Upstream and downstream use valid/ready handshakes.
- Used where area matters more than latency; a small-area alternative to the ripple-carry adder.

Parameters:
- WIDTH, 8, operand/result width in bits (must be >= 2).
- CNT_W, $clog2(WIDTH), bit-counter width (derived; not to be overridden).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands/op valid
- in_ready  output  1  controller can accept (combinational = state==IDLE)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  0: A+B, 1: A-B
- out_valid  output  1  result valid (state==DONE)
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of MSB (for sub: 1 = no borrow)
- ovf  output  1  signed overflow
- busy  output  1  state==RUN

Behaviour:
- Reset (async, rst_n low): state=IDLE; all registers (a_sr, b_sr, sum_sr, carry, count, cout, ovf) cleared to 0.
  - Outputs during and after reset: out_valid=0, busy=0, sum=0, cout=0, ovf=0, in_ready=1.
  - Reset mid-RUN or in DONE discards the operation; no partial result is ever flagged valid.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE: on an edge with in_valid&in_ready:
  - a_sr<=a; b_sr<= sub ? ~b : b; carry<=sub; count<=0; state<=RUN.
  - in_valid without accept has no effect.
- RUN, each edge:
  - Full-adder cell inputs are a_sr[0], b_sr[0], carry.
  - sum_sr <= {fa_sum, sum_sr[WIDTH-1:1]}; a_sr and b_sr shift right by one; carry<=fa_cout; count<=count+1.
  - When count==WIDTH-2: cin_msb<=fa_cout (this is the carry into the MSB).
  - When count==WIDTH-1: cout<=fa_cout; ovf<=cin_msb^fa_cout; state<=DONE.
- Latency: out_valid rises exactly WIDTH clock edges after the accepting edge.
- Inputs a/b/sub/in_valid are ignored during RUN and DONE; changing operands mid-op has no effect.
- DONE: out_valid=1; sum/cout/ovf held stable until out_valid&out_ready, then state<=IDLE.
  - out_ready low stalls indefinitely with outputs held.
- Minimum issue interval is WIDTH+2 cycles (accept, WIDTH RUN edges, one DONE handshake edge; in_ready returns in the IDLE cycle). No accept happens in the DONE cycle.
- sum mirrors sum_sr and is only meaningful while out_valid=1. It is deterministic but unchecked during RUN.
- Arithmetic:
  - Result is modulo 2^WIDTH.
  - Subtract is two's complement (~b + 1 via carry-in).
  - ovf = carry-into-MSB XOR carry-out-of-MSB.
- Counter never wraps: it is cleared on accept, and the final increment at WIDTH-1 is don't-care.

Decomposition:
- Shared package serial_adder_pkg: state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2); localparam helper for CNT_W.
- One sub-module: fa_cell (1-bit full adder: s=x^y^c, co=(x&y)|((x^y)&c)), instantiated once. All sequencing stays in serial_adder_ctrl.

Test Plan:
- WIDTH=8, a=8'h3C, b=8'h25, sub=0 -> sum=8'h61, cout=0, ovf=0; out_valid high exactly 8 edges after accept; busy high for those 8 cycles.
- a=8'hFF, b=8'h01, sub=0 -> sum=8'h00, cout=1, ovf=0. Then a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1.
- sub=1: a=8'h05, b=8'h07 -> sum=8'hFE, cout=0, ovf=0. Then a=8'h80, b=8'h01 -> sum=8'h7F, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, and pulse in_valid with new operands meanwhile -> out_valid/sum/cout/ovf stable, in_ready=0, new operands not captured. Raise out_ready -> in_ready=1 the next cycle, and the following op computes correctly.
- Operand change mid-RUN: change a/b on every RUN cycle -> result matches the operands captured at accept.
- Async reset at RUN bit 3 (mid-cycle, not edge-aligned) -> outputs go to 0 immediately and in_ready=1. After release, 8'h10+8'h20 -> 8'h30 with correct latency; back-to-back ops issued every 10 cycles when out_ready is tied high.
